sub_arbiter: RTL and testbench
==============================

Name: sub_arbiter

Overview:
- Shares one registered 16-bit subtract unit among NUM_REQ requesters (ALU issue, branch compare, address calc, debug).
- Round-robin arbitration, one transaction in flight, valid/ready on request side, valid/ready on response side.
- Returns the difference plus borrow and zero flags, tagged with the requester index.
- Sits in the ALU, between the issue logic and the subtract datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width
- ID_W, $clog2(NUM_REQ), requester tag width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept, at most one bit high
- req_a  in  NUM_REQ*WIDTH  packed minuends, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  packed subtrahends, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  index of requester that owns the result
- rsp_diff  out  WIDTH  a - b, modulo 2^WIDTH
- rsp_borrow  out  1  1 when a < b (unsigned)
- rsp_zero  out  1  1 when rsp_diff == 0
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (sync, rst=1 at rising edge): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_diff=0, rsp_borrow=0, rsp_zero=0, busy=0, req_ready=0. rst overrides all other inputs.
- FSM states:
  - IDLE: grant logic active. grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ. req_ready[grant] is driven combinationally in the same cycle. On that edge: capture req_a/req_b of grant into op regs, grant into id reg, go to EXEC. No valid request: stay in IDLE.
  - EXEC: sub unit enabled for one cycle and registers diff/borrow. Always goes to RESP next.
  - RESP: rsp_valid=1. rsp_* comes from the registered result and is held stable while rsp_ready=0. On rsp_valid&&rsp_ready: go to IDLE and set rr_ptr = (id+1) mod NUM_REQ.
- req_ready is 0 in EXEC and RESP. There is no accept during backpressure.
- Latency: accept at cycle T, rsp_valid at T+2. Maximum throughput is one op per 3 cycles.
- Requesters hold req_valid and operands stable until req_ready. Withdrawing req_valid before grant is legal; that requester is simply skipped.
- rr_ptr advances only on response completion, never on an idle cycle.
- Arithmetic: diff = a - b truncated to WIDTH. borrow is the inverted carry-out of a + ~b + 1, i.e. unsigned a < b. zero is computed on the truncated diff.
- Reset mid-operation (EXEC or RESP): the transaction is dropped with no response, and the same reset values apply.
- Single requester asserting continuously: granted every 3 cycles, pointer wraps past idle requesters.

Decomposition:
- Shared package/include sub_arbiter_pkg:
  - state encodings IDLE=2'd0, EXEC=2'd1, RESP=2'd2
  - default WIDTH=16, NUM_REQ=4
- Sub-module sub_unit:
  - ports: clk, rst, en, a, b, diff, borrow
  - registered subtract, sync active-high reset to 0, updates only when en=1

Test Plan:
- Requester 0 only, a=16'h0005, b=16'h0003 -> req_ready[0] same cycle; rsp_valid 2 cycles later; diff=16'h0002, borrow=0, zero=0, rsp_id=0.
- Requester 2, a=16'h0003, b=16'h0005 -> diff=16'hFFFE, borrow=1, zero=0, rsp_id=2.
- Requester 1, a=b=16'h0000 -> diff=16'h0000, zero=1, borrow=0. Then a=b=16'h1234 -> zero=1.
- All four req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0, one every 3 cycles. After the grant to 2, only req 0 and req 3 valid -> req 3 granted first.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_* stable, all req_ready=0, busy=1. Release -> accepted, IDLE next cycle.
- rst=1 during EXEC -> next cycle rsp_valid=0, busy=0, rr_ptr=0, and the dropped op never appears on the response side.

Source files
------------

// File: rtl/sub_arbiter_pkg.sv
// Shared encodings and defaults for the shared-subtractor arbiter slice.
package sub_arbiter_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_NUM_REQ = 4;

endpackage

// File: rtl/sub_arbiter_sub_unit.sv
// Registered WIDTH-bit subtractor producing a - b and an unsigned borrow.
module sub_unit
    import sub_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0]   sum_next;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;

    // a + ~b + 1: carry-out low means a < b
    assign sum_next = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
        end else if (en) begin
            diff_reg   <= sum_next[WIDTH-1:0];
            borrow_reg <= ~sum_next[WIDTH];
        end
    end

    assign diff   = diff_reg;
    assign borrow = borrow_reg;

endmodule

// File: rtl/sub_arbiter.sv
// Round-robin arbiter sharing one registered subtractor among NUM_REQ requesters,
// one transaction in flight, results tagged with the owning requester index.
module sub_arbiter
    import sub_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int WIDTH   = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_diff,
    output logic                       rsp_borrow,
    output logic                       rsp_zero,
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [1:0]       state_reg;
    logic [ID_W-1:0]  rr_ptr_reg;
    logic [ID_W-1:0]  id_reg;
    logic [WIDTH-1:0] op_a_reg;
    logic [WIDTH-1:0] op_b_reg;
    logic             zero_reg;

    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Search starts at rr_ptr and wraps modulo NUM_REQ; first valid wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Gated by rst so no requester sees a handshake while reset is applied.
    always_comb begin
        req_ready = '0;
        if (!rst && state_reg == IDLE && grant_found)
            req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            id_reg     <= '0;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            zero_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        op_a_reg  <= a_arr[grant_idx];
                        op_b_reg  <= b_arr[grant_idx];
                        id_reg    <= grant_idx;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    // a - b truncates to zero exactly when the operands match
                    zero_reg  <= (op_a_reg == op_b_reg);
                    state_reg <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg  <= IDLE;
                        rr_ptr_reg <= (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + ID_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    sub_unit #(
        .WIDTH (WIDTH)
    ) u_sub_unit (
        .clk    (clk),
        .rst    (rst),
        .en     (state_reg == EXEC),
        .a      (op_a_reg),
        .b      (op_b_reg),
        .diff   (rsp_diff),
        .borrow (rsp_borrow)
    );

    assign rsp_valid = (state_reg == RESP);
    assign rsp_id    = id_reg;
    assign rsp_zero  = zero_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_sub_arbiter.sv
// Directed testbench for sub_arbiter with hand-computed expectations.
module tb_sub_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [1:0]               rsp_id;
    logic [WIDTH-1:0]         rsp_diff;
    logic                     rsp_borrow;
    logic                     rsp_zero;
    logic                     busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    sub_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_diff   (rsp_diff),
        .rsp_borrow (rsp_borrow),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are then driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [15:0] a, input logic [15:0] b);
        req_a[idx*WIDTH +: WIDTH] = a;
        req_b[idx*WIDTH +: WIDTH] = b;
    endtask

    // One isolated transaction from requester idx with rsp_ready held high.
    task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ed, input logic eb, input logic ez);
        req_valid = '0;
        req_valid[idx] = 1'b1;
        set_ops(idx, a, b);
        rsp_ready = 1'b1;
        #1;
        check("grant_same_cycle", 32'(req_ready), 32'(1 << idx));
        step();
        req_valid = '0;
        #1;
        check("exec_no_valid", 32'(rsp_valid), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        step();
        check("rsp_valid_t2", 32'(rsp_valid), 32'd1);
        check("rsp_diff", 32'(rsp_diff), 32'(ed));
        check("rsp_borrow", 32'(rsp_borrow), 32'(eb));
        check("rsp_zero", 32'(rsp_zero), 32'(ez));
        check("rsp_id", 32'(rsp_id), 32'(idx));
        $display("txn req=%0d a=%h b=%h -> diff=%h borrow=%0d zero=%0d id=%0d",
                 idx, a, b, rsp_diff, rsp_borrow, rsp_zero, rsp_id);
        step();
        check("back_to_idle", 32'(busy), 32'd0);
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) step();
        req_valid = 4'b1111;
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_diff", 32'(rsp_diff), 32'd0);
        check("reset_rsp_zero", 32'(rsp_zero), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        step();
        rst = 1'b0;

        do_op(0, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
        do_op(2, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0);
        do_op(1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
        do_op(1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1);
        do_op(3, 16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0);

        // rr_ptr is 0 after requester 3; all four contend
        for (int i = 0; i < NUM_REQ; i++) set_ops(i, 16'(16'h0010 + i), 16'h0001);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            check("rr_grant", 32'(req_ready), 32'(1 << exp_order[n]));
            step();
            if (n == 2) req_valid = 4'b1001;
            step();
            check("rr_rsp_id", 32'(rsp_id), 32'(exp_order[n]));
            check("rr_rsp_diff", 32'(rsp_diff), 32'(16'h000F + exp_order[n]));
            $display("txn rr grant=%0d diff=%h", rsp_id, rsp_diff);
            step();
        end
        req_valid = '0;

        // Backpressure: requester 1, hold rsp_ready low for 5 cycles in RESP
        set_ops(1, 16'h0007, 16'h0002);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        step();
        req_valid = 4'b1101;
        step();
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_diff", 32'(rsp_diff), 32'h0005);
            check("bp_id", 32'(rsp_id), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            step();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        step();
        check("bp_release_idle", 32'(busy), 32'd0);
        $display("txn backpressure req=1 diff=0005 released");

        // rr_ptr now 2; two idle cycles must not move it, so {0,3} grants 3
        step();
        step();
        req_valid = 4'b1001;
        #1;
        check("rr_no_idle_advance", 32'(req_ready), 32'b1000);
        req_valid = '0;

        // Reset in EXEC with rr_ptr nonzero: drop op and return pointer to 0
        set_ops(3, 16'h0009, 16'h0004);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_exec_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_no_ghost_rsp", 32'(rsp_valid), 32'd0);
        end
        req_valid = 4'b1001;
        #1;
        check("rst_rr_ptr_zero", 32'(req_ready), 32'b0001);
        $display("txn reset during EXEC, op dropped");
        req_valid = '0;
        step();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
